// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      MISS   = 2'b01,
      RESUME = 2'b10
   } miss_state_t;

   localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline-side signals exchanged with the hazard controller.
// The pipeline drives through the master modport; the controller uses slave.
interface hazard_unit_if #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int COUNT_WIDTH    = 32
);

   logic [REG_ADDR_WIDTH-1:0] Rs1D;
   logic [REG_ADDR_WIDTH-1:0] Rs2D;
   logic [REG_ADDR_WIDTH-1:0] Rs1E;
   logic [REG_ADDR_WIDTH-1:0] Rs2E;
   logic [REG_ADDR_WIDTH-1:0] RdE;
   logic [REG_ADDR_WIDTH-1:0] RdM;
   logic [REG_ADDR_WIDTH-1:0] RdW;
   logic                      RegWriteM;
   logic                      RegWriteW;
   logic                      ResultSrcE0;
   logic                      PCSrcE;
   logic                      MemAccessM;
   logic                      CacheHitM;
   logic                      MemReadyM;

   logic [1:0]                ForwardAE;
   logic [1:0]                ForwardBE;
   logic                      StallF;
   logic                      StallD;
   logic                      StallE;
   logic                      StallM;
   logic                      FlushD;
   logic                      FlushE;
   logic                      FlushW;
   logic [COUNT_WIDTH-1:0]    MissCycles;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
      output MemAccessM, CacheHitM, MemReadyM,
      input  ForwardAE, ForwardBE,
      input  StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushW,
      input  MissCycles
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
      input  MemAccessM, CacheHitM, MemReadyM,
      output ForwardAE, ForwardBE,
      output StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushW,
      output MissCycles
   );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding comparator for one execute-stage source register.
// The memory stage result is newer than writeback, so it wins; x0 is never forwarded.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic [REG_ADDR_WIDTH-1:0] RsE,
   input  logic [REG_ADDR_WIDTH-1:0] RdM,
   input  logic [REG_ADDR_WIDTH-1:0] RdW,
   input  logic                      RegWriteM,
   input  logic                      RegWriteW,
   output fwd_sel_t                  Forward
);

   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = REG_ADDR_WIDTH'(REG_ZERO);

   // Pick the youngest in-flight producer of RsE, falling back to the register file.
   always_comb begin
      Forward = FWD_RF;
      if (RegWriteM && (RdM != ZERO_REG) && (RdM == RsE)) begin
         Forward = FWD_M;
      end else if (RegWriteW && (RdW != ZERO_REG) && (RdW == RsE)) begin
         Forward = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding, load-use interlock,
// branch flushes and a data-cache miss freeze with a saturating stall counter.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int COUNT_WIDTH    = 32
) (
   input logic          clk,
   input logic          rst,
   hazard_unit_if.slave hz
);

   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = REG_ADDR_WIDTH'(REG_ZERO);

   fwd_sel_t               fwdA;
   fwd_sel_t               fwdB;
   miss_state_t            state;
   miss_state_t            nextState;
   logic                   missStall;
   logic                   lwStall;
   logic                   active;
   logic [COUNT_WIDTH-1:0] missCount;

   hazard_fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) fwdSelA (
      .RsE       (hz.Rs1E),
      .RdM       (hz.RdM),
      .RdW       (hz.RdW),
      .RegWriteM (hz.RegWriteM),
      .RegWriteW (hz.RegWriteW),
      .Forward   (fwdA)
   );

   hazard_fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) fwdSelB (
      .RsE       (hz.Rs2E),
      .RdM       (hz.RdM),
      .RdW       (hz.RdW),
      .RegWriteM (hz.RegWriteM),
      .RegWriteW (hz.RegWriteW),
      .Forward   (fwdB)
   );

   // While reset is held every control output is forced quiet.
   assign active = !rst;

   // A load in E whose destination feeds the instruction in D must hold D for one cycle.
   always_comb begin
      lwStall = hz.ResultSrcE0 && (hz.RdE != ZERO_REG) &&
                ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
   end

   // Miss FSM state register; reset abandons any miss in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: a refill-complete pulse may coincide with the miss detection.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (hz.MemAccessM && !hz.CacheHitM) begin
               nextState = hz.MemReadyM ? RESUME : MISS;
            end
         end
         MISS: begin
            if (hz.MemReadyM) begin
               nextState = RESUME;
            end
         end
         RESUME:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // FSM output: stall from the detection cycle through the refill-complete cycle.
   always_comb begin
      missStall = 1'b0;
      case (state)
         IDLE:    missStall = hz.MemAccessM && !hz.CacheHitM;
         MISS:    missStall = 1'b1;
         default: missStall = 1'b0;
      endcase
   end

   // Saturating count of miss-stall cycles for performance monitoring.
   always_ff @(posedge clk) begin
      if (rst) begin
         missCount <= '0;
      end else if (missStall && (missCount != {COUNT_WIDTH{1'b1}})) begin
         missCount <= missCount + COUNT_WIDTH'(1);
      end
   end

   // A miss freezes the whole pipeline, so branch and load-use flushes wait until it clears.
   always_comb begin
      hz.ForwardAE = active ? fwdA : FWD_RF;
      hz.ForwardBE = active ? fwdB : FWD_RF;
      hz.StallF    = active && (lwStall || missStall);
      hz.StallD    = active && (lwStall || missStall);
      hz.StallE    = active && missStall;
      hz.StallM    = active && missStall;
      hz.FlushW    = active && missStall;
      hz.FlushD    = active && hz.PCSrcE && !missStall;
      hz.FlushE    = active && (lwStall || hz.PCSrcE) && !missStall;
   end

   assign hz.MissCycles = missCount;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; a second instance with a
// 4-bit counter shares the same stimulus to exercise counter saturation.
module tb_hazard_unit;

   logic clk;
   logic rst;
   int   checkCount;
   int   errorCount;

   hazard_unit_if #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(32)) bus ();
   hazard_unit_if #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(4))  busS ();

   hazard_unit #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (bus)
   );

   hazard_unit #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(4)) dutSmall (
      .clk (clk),
      .rst (rst),
      .hz  (busS)
   );

   assign busS.Rs1D        = bus.Rs1D;
   assign busS.Rs2D        = bus.Rs2D;
   assign busS.Rs1E        = bus.Rs1E;
   assign busS.Rs2E        = bus.Rs2E;
   assign busS.RdE         = bus.RdE;
   assign busS.RdM         = bus.RdM;
   assign busS.RdW         = bus.RdW;
   assign busS.RegWriteM   = bus.RegWriteM;
   assign busS.RegWriteW   = bus.RegWriteW;
   assign busS.ResultSrcE0 = bus.ResultSrcE0;
   assign busS.PCSrcE      = bus.PCSrcE;
   assign busS.MemAccessM  = bus.MemAccessM;
   assign busS.CacheHitM   = bus.CacheHitM;
   assign busS.MemReadyM   = bus.MemReadyM;

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Step to just after the next rising edge so new inputs never race the edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      bus.Rs1D        = '0;
      bus.Rs2D        = '0;
      bus.Rs1E        = '0;
      bus.Rs2E        = '0;
      bus.RdE         = '0;
      bus.RdM         = '0;
      bus.RdW         = '0;
      bus.RegWriteM   = 1'b0;
      bus.RegWriteW   = 1'b0;
      bus.ResultSrcE0 = 1'b0;
      bus.PCSrcE      = 1'b0;
      bus.MemAccessM  = 1'b0;
      bus.CacheHitM   = 1'b0;
      bus.MemReadyM   = 1'b0;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst = 1'b1;
      clearInputs();

      // Reset: every hazard source active, yet outputs must stay quiet.
      applyStimulus();
      bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.Rs1E = 5'd5;
      bus.MemAccessM = 1'b1; bus.CacheHitM = 1'b0;
      bus.ResultSrcE0 = 1'b1; bus.RdE = 5'd3; bus.Rs1D = 5'd3;
      bus.PCSrcE = 1'b1;
      #1;
      checkOutput("rst_fwdA",   32'(bus.ForwardAE), 32'd0);
      checkOutput("rst_stallF", 32'(bus.StallF), 32'd0);
      checkOutput("rst_stallE", 32'(bus.StallE), 32'd0);
      checkOutput("rst_flushD", 32'(bus.FlushD), 32'd0);
      checkOutput("rst_flushE", 32'(bus.FlushE), 32'd0);
      checkOutput("rst_flushW", 32'(bus.FlushW), 32'd0);
      applyStimulus();
      checkOutput("rst_count",  bus.MissCycles, 32'd0);
      checkOutput("rst_countS", 32'(busS.MissCycles), 32'd0);
      clearInputs();
      rst = 1'b0;

      // Forwarding priority and x0 suppression.
      applyStimulus();
      bus.RdM = 5'd5; bus.RdW = 5'd5; bus.Rs2E = 5'd5;
      bus.RegWriteM = 1'b1; bus.RegWriteW = 1'b1;
      #1;
      checkOutput("fwdB_M",     32'(bus.ForwardBE), 32'd2);
      checkOutput("fwdA_none",  32'(bus.ForwardAE), 32'd0);
      bus.RegWriteM = 1'b0;
      #1;
      checkOutput("fwdB_W",     32'(bus.ForwardBE), 32'd1);
      bus.RegWriteM = 1'b1; bus.RdM = 5'd0; bus.RdW = 5'd0; bus.Rs2E = 5'd0;
      #1;
      checkOutput("fwdB_x0",    32'(bus.ForwardBE), 32'd0);
      bus.Rs1E = 5'd7; bus.RdW = 5'd7; bus.RdM = 5'd6;
      #1;
      checkOutput("fwdA_W",     32'(bus.ForwardAE), 32'd1);
      bus.RdM = 5'd7;
      #1;
      checkOutput("fwdA_M",     32'(bus.ForwardAE), 32'd2);

      // Load-use interlock.
      applyStimulus();
      clearInputs();
      bus.ResultSrcE0 = 1'b1; bus.RdE = 5'd3; bus.Rs1D = 5'd3;
      #1;
      checkOutput("lu_stallF",  32'(bus.StallF), 32'd1);
      checkOutput("lu_stallD",  32'(bus.StallD), 32'd1);
      checkOutput("lu_flushE",  32'(bus.FlushE), 32'd1);
      checkOutput("lu_stallE",  32'(bus.StallE), 32'd0);
      checkOutput("lu_flushD",  32'(bus.FlushD), 32'd0);
      checkOutput("lu_flushW",  32'(bus.FlushW), 32'd0);
      applyStimulus();
      clearInputs();
      #1;
      checkOutput("lu_after",   32'(bus.StallF), 32'd0);
      bus.ResultSrcE0 = 1'b1; bus.RdE = 5'd3; bus.Rs2D = 5'd3;
      #1;
      checkOutput("lu_rs2",     32'(bus.StallD), 32'd1);
      bus.RdE = 5'd0; bus.Rs2D = 5'd0;
      #1;
      checkOutput("lu_x0",      32'(bus.StallF), 32'd0);
      bus.ResultSrcE0 = 1'b0; bus.RdE = 5'd3; bus.Rs1D = 5'd3;
      #1;
      checkOutput("lu_noload",  32'(bus.FlushE), 32'd0);

      // Cache miss: detect at cycle 0, refill pulse at cycle 4, RESUME at cycle 5.
      applyStimulus();
      clearInputs();
      bus.MemAccessM = 1'b1; bus.CacheHitM = 1'b0;
      for (int c = 0; c <= 5; c++) begin
         bus.MemReadyM = (c == 4);
         #1;
         checkOutput($sformatf("miss_stallF_c%0d", c), 32'(bus.StallF), (c <= 4) ? 32'd1 : 32'd0);
         checkOutput($sformatf("miss_stallM_c%0d", c), 32'(bus.StallM), (c <= 4) ? 32'd1 : 32'd0);
         checkOutput($sformatf("miss_flushW_c%0d", c), 32'(bus.FlushW), (c <= 4) ? 32'd1 : 32'd0);
         if (c == 5) begin
            checkOutput("miss_count", bus.MissCycles, 32'd5);
         end
         applyStimulus();
      end
      clearInputs();

      // Branch held in E during a miss acts only once the stall releases.
      bus.PCSrcE = 1'b1; bus.MemAccessM = 1'b1; bus.CacheHitM = 1'b0;
      for (int c = 0; c <= 3; c++) begin
         bus.MemReadyM = (c == 2);
         #1;
         checkOutput($sformatf("br_flushD_c%0d", c), 32'(bus.FlushD), (c == 3) ? 32'd1 : 32'd0);
         checkOutput($sformatf("br_flushE_c%0d", c), 32'(bus.FlushE), (c == 3) ? 32'd1 : 32'd0);
         checkOutput($sformatf("br_stallD_c%0d", c), 32'(bus.StallD), (c <= 2) ? 32'd1 : 32'd0);
         applyStimulus();
      end
      checkOutput("br_count", bus.MissCycles, 32'd8);
      clearInputs();

      // Refill complete in the same cycle the miss is seen: one stall cycle only.
      bus.MemAccessM = 1'b1; bus.CacheHitM = 1'b0; bus.MemReadyM = 1'b1;
      #1;
      checkOutput("fast_stall0", 32'(bus.StallE), 32'd1);
      applyStimulus();
      bus.MemReadyM = 1'b0;
      #1;
      checkOutput("fast_stall1", 32'(bus.StallE), 32'd0);
      checkOutput("fast_count",  bus.MissCycles, 32'd9);
      applyStimulus();
      clearInputs();

      // Reset in the middle of a miss abandons it.
      bus.MemAccessM = 1'b1; bus.CacheHitM = 1'b0;
      applyStimulus();
      applyStimulus();
      rst = 1'b1;
      #1;
      checkOutput("rmid_stallF_inrst", 32'(bus.StallF), 32'd0);
      applyStimulus();
      rst = 1'b0;
      bus.MemAccessM = 1'b0;
      #1;
      checkOutput("rmid_count",  bus.MissCycles, 32'd0);
      checkOutput("rmid_countS", 32'(busS.MissCycles), 32'd0);
      checkOutput("rmid_stallF", 32'(bus.StallF), 32'd0);
      bus.MemAccessM = 1'b1; bus.CacheHitM = 1'b1;
      #1;
      checkOutput("rmid_idle",   32'(bus.StallM), 32'd0);

      // Saturation: 20 miss cycles on the 4-bit counter stick at 15.
      applyStimulus();
      clearInputs();
      bus.MemAccessM = 1'b1; bus.CacheHitM = 1'b0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus();
      end
      checkOutput("sat_mid",   32'(busS.MissCycles), 32'd10);
      for (int i = 0; i < 10; i++) begin
         applyStimulus();
      end
      checkOutput("sat_small", 32'(busS.MissCycles), 32'd15);
      checkOutput("sat_big",   bus.MissCycles, 32'd20);
      bus.MemReadyM = 1'b1;
      applyStimulus();
      clearInputs();
      applyStimulus();
      checkOutput("sat_hold",  32'(busS.MissCycles), 32'd15);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
